// File: rtl/bin2bcd_arb.sv
// Round-robin arbiter that shares one binary-to-BCD converter among NREQ requesters.
// Optional feature: define BIN2BCD_ARB_TIMEOUT_EN to enable the WAIT-state timeout.
module bin2bcd_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              Clock,
  input  logic              Rst_,
  input  logic [NREQ-1:0]   Req,
  input  logic [8*NREQ-1:0] Bin,
  output logic [NREQ-1:0]   Ack,
  output logic [11:0]       Bcd_out,
  output logic              Busy,
  output logic              Err,
  output logic              conv_Start,
  output logic [7:0]        conv_Bin,
  input  logic              conv_Done,
  input  logic [11:0]       conv_Bcd
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     gnt_q;
  logic [7:0]        opnd_q;
  logic [11:0]       res_q;
  logic [NREQ-1:0]   ack_q;
  logic              start_q;

  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [IW:0]       scan_idx;

`ifdef BIN2BCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q;
  logic              err_q;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  // Scan downward so the last hit is the one closest above the pointer.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NREQ)) scan_idx = scan_idx - (IW+1)'(NREQ);
      if (Req[scan_idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[IW-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or negedge Rst_) begin
    if (!Rst_) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      opnd_q  <= 8'h00;
      res_q   <= 12'h000;
      ack_q   <= '0;
      start_q <= 1'b0;
`ifdef BIN2BCD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
`ifdef BIN2BCD_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt_q   <= win_idx;
            opnd_q  <= Bin[8*win_idx +: 8];
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef BIN2BCD_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_Done) begin
            res_q   <= conv_Bcd;
            ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
            state_q <= S_DELIVER;
          end
`ifdef BIN2BCD_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            res_q   <= 12'hFFF;
            err_q   <= 1'b1;
            ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
            state_q <= S_DELIVER;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
`endif
        end
        S_DELIVER: begin
          ptr_q   <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ack        = ack_q;
  assign Bcd_out    = res_q;
  assign Busy       = (state_q != S_IDLE);
  assign conv_Start = start_q;
  assign conv_Bin   = opnd_q;

endmodule

// File: tb/tb_bin2bcd_arb.sv
// Self-checking bench for bin2bcd_arb: behavioural converter model plus an expected-result queue.
module tb_bin2bcd_arb;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;

  logic              Clock;
  logic              Rst_;
  logic [NREQ-1:0]   Req;
  logic [8*NREQ-1:0] Bin;
  logic [NREQ-1:0]   Ack;
  logic [11:0]       Bcd_out;
  logic              Busy;
  logic              Err;
  logic              conv_Start;
  logic [7:0]        conv_Bin;
  logic              conv_Done;
  logic [11:0]       conv_Bcd;

  bin2bcd_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Rst_(Rst_), .Req(Req), .Bin(Bin), .Ack(Ack),
    .Bcd_out(Bcd_out), .Busy(Busy), .Err(Err), .conv_Start(conv_Start),
    .conv_Bin(conv_Bin), .conv_Done(conv_Done), .conv_Bcd(conv_Bcd)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [11:0]     bcd;
    logic            err;
    logic [7:0]      bin;
    int              lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   conv_lat  = 3;
  int   ign_req   = 0;
  int   ign_done  = 0;
  int   spur_req  = 0;
  int   spur_done = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [7:0] b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  // Converter model: Done pulses conv_lat cycles after it sees Start.
  initial begin
    int         cnt;
    logic [7:0] cbin;
    cnt       = 0;
    cbin      = 8'h00;
    conv_Done = 1'b0;
    conv_Bcd  = 12'h000;
    forever begin
      @(negedge Clock);
      conv_Done = 1'b0;
      if (!Rst_) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          conv_Done = 1'b1;
          conv_Bcd  = to_bcd(cbin);
        end
      end
      if (Rst_ && conv_Start) begin
        if (ign_done < ign_req) ign_done++;
        else begin
          cbin = conv_Bin;
          cnt  = conv_lat;
        end
      end
      if (spur_done < spur_req) begin
        spur_done++;
        conv_Done = 1'b1;
        conv_Bcd  = 12'h321;
      end
    end
  end

  task automatic push(input int idx, input logic [7:0] b, input logic to);
    exp_t e;
    e.ack = NREQ'(1) << idx;
    e.bin = b;
    e.err = to;
    e.bcd = to ? 12'hFFF : to_bcd(b);
    e.lat = to ? TIMEOUT + 1 : conv_lat + 1;
    exp_q.push_back(e);
  endtask

  task automatic set_bin(input int idx, input logic [7:0] b);
    Bin[8*idx +: 8] = b;
  endtask

  int   cyc = 0;
  int   start_cyc = 0;

  // Runs until all expected results are delivered and the arbiter is idle;
  // poke_at > 0 rewrites Bin[0] to 7 on that cycle of the run.
  task automatic run(input int budget, input int min_cyc, input int poke_at);
    logic prev_start;
    logic done;
    exp_t e;
    prev_start = 1'b0;
    done       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      cyc++;
      if (i == poke_at) set_bin(0, 8'd7);
      if (conv_Start) begin
        check("start_pulse", {31'd0, prev_start}, 0);
        start_cyc = cyc;
        if (exp_q.size() > 0) check("conv_bin", {24'd0, conv_Bin}, {24'd0, exp_q[0].bin});
        else check("start_unexp", {31'd0, conv_Start}, 0);
      end
      prev_start = conv_Start;
      if (Ack != '0) begin
        if (exp_q.size() == 0) check("ack_unexp", {28'd0, Ack}, 0);
        else begin
          e = exp_q.pop_front();
          check("ack", {28'd0, Ack}, {28'd0, e.ack});
          check("bcd", {20'd0, Bcd_out}, {20'd0, e.bcd});
          check("err", {31'd0, Err}, {31'd0, e.err});
          check("lat", cyc - start_cyc, e.lat);
        end
        Req = Req & ~Ack;
      end
      if (i >= min_cyc && exp_q.size() == 0 && Req == '0 && !Busy) begin
        done = 1'b1;
        break;
      end
    end
    check("run_done", {31'd0, done}, 1);
    exp_q.delete();
  endtask

  initial begin
    Rst_ = 1'b1;
    Req  = '0;
    Bin  = '0;
    #2 Rst_ = 1'b0;
    #1;
    check("rst_ack",   {28'd0, Ack}, 0);
    check("rst_bcd",   {20'd0, Bcd_out}, 0);
    check("rst_busy",  {31'd0, Busy}, 0);
    check("rst_err",   {31'd0, Err}, 0);
    check("rst_start", {31'd0, conv_Start}, 0);
    check("rst_cbin",  {24'd0, conv_Bin}, 0);
    repeat (2) @(negedge Clock);
    Rst_ = 1'b1;
    @(negedge Clock);

    // Fairness from P=0
    set_bin(0, 8'd0); set_bin(1, 8'd9); set_bin(2, 8'd100); set_bin(3, 8'd199);
    Req = 4'b1111;
    push(0, 8'd0, 0); push(1, 8'd9, 0); push(2, 8'd100, 0); push(3, 8'd199, 0);
    run(200, 0, -1);

    // Single request, largest operand
    set_bin(0, 8'd255);
    Req = 4'b0001;
    push(0, 8'd255, 0);
    run(50, 0, -1);
    check("idle_busy", {31'd0, Busy}, 0);
    check("idle_start", {31'd0, conv_Start}, 0);

    // Bin change while the conversion is in flight
    conv_lat = 6;
    set_bin(0, 8'd42);
    Req = 4'b0001;
    push(0, 8'd42, 0);
    run(50, 0, 3);
    conv_lat = 3;

    // Requester 1 alone moves P to 2
    set_bin(1, 8'd58);
    Req = 4'b0010;
    push(1, 8'd58, 0);
    run(50, 0, -1);

    // Fairness from P=2
    set_bin(0, 8'd0); set_bin(1, 8'd9); set_bin(2, 8'd100); set_bin(3, 8'd199);
    Req = 4'b1111;
    push(2, 8'd100, 0); push(3, 8'd199, 0); push(0, 8'd0, 0); push(1, 8'd9, 0);
    run(200, 0, -1);

    // Contention 3 and 1 with P=2
    set_bin(3, 8'd77); set_bin(1, 8'd150);
    Req = 4'b1010;
    push(3, 8'd77, 0); push(1, 8'd150, 0);
    run(100, 0, -1);

    // P must be back at 2: requester 2 wins over 0
    set_bin(0, 8'd5); set_bin(2, 8'd250);
    Req = 4'b0101;
    push(2, 8'd250, 0); push(0, 8'd5, 0);
    run(100, 0, -1);

    // Reset in the middle of WAIT aborts the transaction
    conv_lat = 10;
    set_bin(1, 8'd33);
    Req = 4'b0010;
    repeat (3) @(posedge Clock);
    #2 Rst_ = 1'b0;
    Req = '0;
    #1;
    check("mid_rst_ack",   {28'd0, Ack}, 0);
    check("mid_rst_busy",  {31'd0, Busy}, 0);
    check("mid_rst_start", {31'd0, conv_Start}, 0);
    check("mid_rst_bcd",   {20'd0, Bcd_out}, 0);
    @(posedge Clock);
    #2 Rst_ = 1'b1;
    conv_lat = 3;
    spur_req++;
    run(40, 20, -1);
    check("spur_busy", {31'd0, Busy}, 0);

    // P reset to 0: requester 0 wins over 3
    set_bin(0, 8'd1); set_bin(3, 8'd128);
    Req = 4'b1001;
    push(0, 8'd1, 0); push(3, 8'd128, 0);
    run(100, 0, -1);

`ifdef BIN2BCD_ARB_TIMEOUT_EN
    // Withheld Done: requester 0 times out, requester 1 is served next
    ign_req++;
    set_bin(0, 8'd12); set_bin(1, 8'd99);
    Req = 4'b0011;
    push(0, 8'd12, 1); push(1, 8'd99, 0);
    run(300, 0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
